// File: rtl/lbist_misr_compactor_pkg.sv
// Shared constants for the LBIST response-compaction path: FSM encoding,
// signature width and the default MISR feedback polynomial.
package lbist_misr_compactor_pkg;

   localparam int unsigned SIG_W = 8;
   localparam logic [SIG_W-1:0] POLY_DEFAULT = 8'h1D;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/lbist_misr_compactor_misr_core.sv
// MISR datapath: combinational next-signature function plus the signature
// register with synchronous seed load and compaction enable.
module misr_core #(
   parameter int unsigned        WIDTH = 8,
   parameter logic [WIDTH-1:0]   POLY  = 8'h1D
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] next_o,
   output logic [WIDTH-1:0] sig_o
);

   logic [WIDTH-1:0] sig_q;
   logic [WIDTH-1:0] sig_d;
   logic             fb_s;

   // Next signature: shift up, fold in the response word, apply feedback taps.
   always_comb begin
      fb_s     = sig_q[WIDTH-1];
      sig_d    = {WIDTH{1'b0}};
      sig_d[0] = din_i[0] ^ (POLY[0] & fb_s);
      for (int i = 1; i < int'(WIDTH); i++) begin
         sig_d[i] = sig_q[i-1] ^ din_i[i] ^ (POLY[i] & fb_s);
      end
   end

   // Signature register; a load wins over compaction.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sig_q <= {WIDTH{1'b0}};
      end else if (load_i) begin
         sig_q <= seed_i;
      end else if (en_i) begin
         sig_q <= sig_d;
      end else begin
         sig_q <= sig_q;
      end
   end

   assign next_o = sig_d;
   assign sig_o  = sig_q;

endmodule

// File: rtl/lbist_misr_compactor.sv
// LBIST response compactor: folds adder sum words into a MISR over a fixed
// number of patterns and reports the golden-signature compare to the controller.
module lbist_misr_compactor
   import lbist_misr_compactor_pkg::*;
#(
   parameter int unsigned      WIDTH      = SIG_W,
   parameter logic [WIDTH-1:0] POLY       = WIDTH'(POLY_DEFAULT),
   parameter logic [WIDTH-1:0] SEED       = {WIDTH{1'b0}},
   parameter int unsigned      N_PATTERNS = 256,
   parameter logic [WIDTH-1:0] GOLDEN     = {WIDTH{1'b0}}
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             din_valid_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [WIDTH-1:0] signature_o,
   output logic [15:0]      count_o
);

   localparam logic [15:0] LAST_CNT = 16'(N_PATTERNS - 1);

   state_e           state_q;
   logic [15:0]      count_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic             load_s;
   logic             en_s;
   logic [WIDTH-1:0] next_s;
   logic [WIDTH-1:0] sig_s;

   // Datapath controls; abort suppresses both load and compaction.
   always_comb begin
      load_s = 1'b0;
      en_s   = 1'b0;
      if (abort_i) begin
         load_s = 1'b0;
         en_s   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: load_s = start_i;
            ST_RUN:           en_s   = din_valid_i;
            default: begin
               load_s = 1'b0;
               en_s   = 1'b0;
            end
         endcase
      end
   end

   misr_core #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_misr_core (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (load_s),
      .en_i   (en_s),
      .seed_i (SEED),
      .din_i  (din_i),
      .next_o (next_s),
      .sig_o  (sig_s)
   );

   // Run-control FSM with pattern counter and registered status outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         count_q <= 16'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else if (abort_i) begin
         // count is left untouched so a debugger can see how far the run got
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state_q <= ST_RUN;
                  count_q <= 16'd0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (din_valid_i) begin
                  count_q <= count_q + 16'd1;
                  if (count_q == LAST_CNT) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (next_s == GOLDEN);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               pass_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q & done_q;
   assign signature_o = sig_s;
   assign count_o     = count_q;

endmodule

// File: tb/tb_lbist_misr_compactor.sv
// Self-checking bench: three compactor instances with different run lengths,
// seeds and golden values, shared stimulus, and a polynomial-arithmetic model.
module tb_lbist_misr_compactor;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic       din_valid;
   logic [7:0] din;

   logic       busy_w [3];
   logic       done_w [3];
   logic       pass_w [3];
   logic [7:0] sig_w  [3];
   logic [15:0] cnt_w [3];

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // model parameters per instance
   int         np   [3];
   logic [7:0] gold [3];
   logic [7:0] seed [3];

   // model state per instance
   logic [7:0] m_sig  [3];
   int         m_cnt  [3];
   bit         m_run  [3];
   bit         m_fin  [3];
   bit         m_pass [3];

   logic [7:0] pat [256];
   logic [7:0] first_sig;

   lbist_misr_compactor #(.N_PATTERNS(2), .SEED(8'h00), .GOLDEN(8'h1D)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .din_valid_i(din_valid), .din_i(din),
      .busy_o(busy_w[0]), .done_o(done_w[0]), .pass_o(pass_w[0]),
      .signature_o(sig_w[0]), .count_o(cnt_w[0]));

   lbist_misr_compactor #(.N_PATTERNS(2), .SEED(8'h00), .GOLDEN(8'h1C)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .din_valid_i(din_valid), .din_i(din),
      .busy_o(busy_w[1]), .done_o(done_w[1]), .pass_o(pass_w[1]),
      .signature_o(sig_w[1]), .count_o(cnt_w[1]));

   lbist_misr_compactor #(.N_PATTERNS(256), .SEED(8'hA5), .GOLDEN(8'h00)) dut_c (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .din_valid_i(din_valid), .din_i(din),
      .busy_o(busy_w[2]), .done_o(done_w[2]), .pass_o(pass_w[2]),
      .signature_o(sig_w[2]), .count_o(cnt_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   // Signature as polynomial arithmetic: multiply by x, add the word, reduce.
   function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
      logic [8:0] t;
      t = {s, 1'b0} ^ {1'b0, d};
      if (t[8]) t = t ^ 9'h11D;
      return t[7:0];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_sig[k] = 8'h00; m_cnt[k] = 0;
         m_run[k] = 1'b0; m_fin[k] = 1'b0; m_pass[k] = 1'b0;
      end
   endtask

   task automatic model_step(input bit st, input bit ab, input bit dv, input logic [7:0] d);
      for (int k = 0; k < 3; k++) begin
         if (ab) begin
            m_run[k] = 1'b0; m_fin[k] = 1'b0; m_pass[k] = 1'b0;
         end else if (!m_run[k]) begin
            if (st) begin
               m_sig[k] = seed[k]; m_cnt[k] = 0; m_pass[k] = 1'b0;
               m_run[k] = 1'b1; m_fin[k] = 1'b0;
            end
         end else if (dv) begin
            m_sig[k] = misr_step(m_sig[k], d);
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == np[k]) begin
               m_run[k]  = 1'b0;
               m_fin[k]  = 1'b1;
               m_pass[k] = (m_sig[k] == gold[k]);
            end
         end
      end
   endtask

   task automatic cyc(input bit st, input bit ab, input bit dv, input logic [7:0] d);
      start = st; abort = ab; din_valid = dv; din = d;
      @(posedge clk);
      model_step(st, ab, dv, d);
      #1;
      start = 1'b0; abort = 1'b0; din_valid = 1'b0;
   endtask

   // Every-cycle comparison of all instances against the model.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         for (int k = 0; k < 3; k++) begin
            chk("busy", k, 32'(busy_w[k]), 32'(m_run[k]));
            chk("done", k, 32'(done_w[k]), 32'(m_fin[k]));
            chk("pass", k, 32'(pass_w[k]), 32'(m_fin[k] & m_pass[k]));
            chk("signature", k, 32'(sig_w[k]), 32'(m_sig[k]));
            chk("count", k, 32'(cnt_w[k]), 32'(m_cnt[k]));
         end
      end
   end

   initial begin
      np[0] = 2;   gold[0] = 8'h1D; seed[0] = 8'h00;
      np[1] = 2;   gold[1] = 8'h1C; seed[1] = 8'h00;
      np[2] = 256; gold[2] = 8'h00; seed[2] = 8'hA5;
      rst = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      chk("reset_sig", 0, 32'(sig_w[0]), 32'h00);
      chk("reset_busy", 0, 32'(busy_w[0]), 32'h0);
      chk("reset_done", 0, 32'(done_w[0]), 32'h0);

      // shift without feedback
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h01);
      chk("shift_w1", 0, 32'(sig_w[0]), 32'h01);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("shift_w2", 0, 32'(sig_w[0]), 32'h02);
      chk("shift_done", 0, 32'(done_w[0]), 32'h1);
      chk("shift_count", 0, 32'(cnt_w[0]), 32'd2);

      // feedback path
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h80);
      chk("fb_w1", 0, 32'(sig_w[0]), 32'h80);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("fb_w2", 0, 32'(sig_w[0]), 32'h1D);
      chk("model_fb", 0, 32'(m_sig[0]), 32'h1D);

      // stall, then pass on golden 1D and fail on golden 1C
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h80);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 8'h55);
         chk("stall_sig", 0, 32'(sig_w[0]), 32'h80);
         chk("stall_count", 0, 32'(cnt_w[0]), 32'd1);
      end
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("stall_final", 0, 32'(sig_w[0]), 32'h1D);
      chk("stall_done", 0, 32'(done_w[0]), 32'h1);
      chk("pass_gold1d", 0, 32'(pass_w[0]), 32'h1);
      chk("pass_gold1c", 1, 32'(pass_w[1]), 32'h0);
      chk("model_pass", 0, 32'(m_pass[0]), 32'h1);

      // abort wins over start and din_valid
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, 8'h33);
      cyc(1'b1, 1'b1, 1'b1, 8'h44);
      chk("abort_sig", 0, 32'(sig_w[0]), 32'h33);
      chk("abort_busy", 0, 32'(busy_w[0]), 32'h0);
      chk("abort_done", 0, 32'(done_w[0]), 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk("restart_sig", 0, 32'(sig_w[0]), 32'h00);
      chk("restart_count", 0, 32'(cnt_w[0]), 32'd0);
      chk("restart_busy", 0, 32'(busy_w[0]), 32'h1);

      // asynchronous reset in the middle of a long run
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom));
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_busy", 2, 32'(busy_w[2]), 32'h0);
      chk("arst_done", 2, 32'(done_w[2]), 32'h0);
      chk("arst_pass", 2, 32'(pass_w[2]), 32'h0);
      chk("arst_sig", 2, 32'(sig_w[2]), 32'h00);
      chk("arst_count", 2, 32'(cnt_w[2]), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // randomized traffic with occasional start and abort
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0,
             $urandom_range(0, 3) != 0, 8'($urandom));
      end

      // two identical 256-word runs must give the same signature
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 256; i++) pat[i] = 8'($urandom);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 256; i++) cyc(1'b0, 1'b0, 1'b1, pat[i]);
      chk("run1_done", 2, 32'(done_w[2]), 32'h1);
      first_sig = m_sig[2];
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk("reload_sig", 2, 32'(sig_w[2]), 32'hA5);
      chk("reload_pass", 2, 32'(pass_w[2]), 32'h0);
      chk("reload_done", 2, 32'(done_w[2]), 32'h0);
      chk("reload_busy", 2, 32'(busy_w[2]), 32'h1);
      for (int i = 0; i < 256; i++) cyc(1'b0, 1'b0, 1'b1, pat[i]);
      chk("run2_done", 2, 32'(done_w[2]), 32'h1);
      chk("run2_sig", 2, 32'(sig_w[2]), 32'(first_sig));
      chk("run2_count", 2, 32'(cnt_w[2]), 32'd256);

      repeat (2) @(posedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
